// File: rtl/post_pkg.sv
// Shared definitions for the Acorn POST test-port host master.
// Op codes, pulse counts per command, and default 12 MHz timing.
package post_pkg;

    localparam logic [1:0] OP_RAW        = 2'd0;
    localparam logic [1:0] OP_SYNC       = 2'd1;
    localparam logic [1:0] OP_OUTPUT     = 2'd2;
    localparam logic [1:0] OP_WRITE_BYTE = 2'd3;

    localparam logic [7:0] SYNC_PULSES   = 8'd4;
    localparam logic [7:0] OUTPUT_PULSES = 8'd3;

    localparam int DEF_PWID_CYC  = 6;
    localparam int DEF_PGAP_CYC  = 6;
    localparam int DEF_BREAK_CYC = 300;
    localparam int DEF_TMR_W     = 16;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_HIGH,
        PG_GAP,
        PG_BREAK
    } pg_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_DONE
    } m_state_t;

    function automatic logic [7:0] bit_pulses(input logic b);
        return b ? 8'd2 : 8'd1;
    endfunction

    function automatic logic [7:0] op_pulses(
        input logic [1:0] op,
        input logic [7:0] data
    );
        logic [7:0] n;
        n = 8'd0;
        unique case (op)
            OP_RAW:        n = data;
            OP_SYNC:       n = SYNC_PULSES;
            OP_OUTPUT:     n = OUTPUT_PULSES;
            OP_WRITE_BYTE: n = bit_pulses(data[7]);
            default:       n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/post_pulse_gen.sv
// One testreq pulse train: N x (high, gap) followed by a break.
// Samples the synchronized ack at the end of the final gap.
module post_pulse_gen
    import post_pkg::*;
#(
    parameter int PWID_CYC  = DEF_PWID_CYC,
    parameter int PGAP_CYC  = DEF_PGAP_CYC,
    parameter int BREAK_CYC = DEF_BREAK_CYC,
    parameter int TMR_W     = DEF_TMR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] count,
    input  logic       ack_s,
    output logic       testreq,
    output logic       last_ack,
    output logic       train_done
);

    localparam logic [TMR_W-1:0] T_HIGH = TMR_W'(PWID_CYC - 1);
    localparam logic [TMR_W-1:0] T_GAP  = TMR_W'(PGAP_CYC - 1);
    localparam logic [TMR_W-1:0] T_BRK  = TMR_W'(BREAK_CYC - 1);

    pg_state_t        state;
    logic [TMR_W-1:0] tmr;
    logic [7:0]       pcnt;
    logic             tmr_zero;
    logic             go;

    assign tmr_zero   = (tmr == '0);
    assign go         = start && (count != 8'd0);
    assign train_done = (state == PG_BREAK) && tmr_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PG_IDLE;
            tmr      <= '0;
            pcnt     <= 8'd0;
            testreq  <= 1'b0;
            last_ack <= 1'b0;
        end else begin
            unique case (state)
                PG_IDLE: begin
                    if (go) begin
                        state   <= PG_HIGH;
                        testreq <= 1'b1;
                        tmr     <= T_HIGH;
                        pcnt    <= count;
                    end
                end
                PG_HIGH: begin
                    if (tmr_zero) begin
                        state   <= PG_GAP;
                        testreq <= 1'b0;
                        tmr     <= T_GAP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                PG_GAP: begin
                    if (!tmr_zero) begin
                        tmr <= tmr - 1'b1;
                    end else if (pcnt == 8'd1) begin
                        // final gap: this is the reply window
                        last_ack <= ack_s;
                        state    <= PG_BREAK;
                        tmr      <= T_BRK;
                    end else begin
                        pcnt    <= pcnt - 8'd1;
                        state   <= PG_HIGH;
                        testreq <= 1'b1;
                        tmr     <= T_HIGH;
                    end
                end
                PG_BREAK: begin
                    if (!tmr_zero) begin
                        tmr <= tmr - 1'b1;
                    end else if (go) begin
                        state   <= PG_HIGH;
                        testreq <= 1'b1;
                        tmr     <= T_HIGH;
                        pcnt    <= count;
                    end else begin
                        state <= PG_IDLE;
                    end
                end
                default: begin
                    state   <= PG_IDLE;
                    testreq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/post_host_master.sv
// Host-side POST initiator: decodes byte commands into pulse trains,
// sequences WRITE_BYTE bits and runs the done/ready handshake.
module post_host_master
    import post_pkg::*;
#(
    parameter int PWID_CYC  = DEF_PWID_CYC,
    parameter int PGAP_CYC  = DEF_PGAP_CYC,
    parameter int BREAK_CYC = DEF_BREAK_CYC,
    parameter int TMR_W     = DEF_TMR_W
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       testreq,
    input  logic       testack,
    output logic       done,
    output logic       last_ack
);

    m_state_t   state;
    logic       ack_m;
    logic       ack_s;
    logic       wb;
    logic [6:0] sh;
    logic [2:0] bcnt;

    logic       accept;
    logic [7:0] acc_cnt;
    logic       more;
    logic       train_done;
    logic       pg_start;
    logic [7:0] pg_count;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= testack;
            ack_s <= ack_m;
        end
    end

    assign accept   = cmd_valid && cmd_ready;
    assign acc_cnt  = op_pulses(cmd_op, cmd_data);
    assign more     = (state == M_RUN) && train_done && wb && (bcnt != 3'd0);
    assign pg_start = (accept && (acc_cnt != 8'd0)) || more;
    assign pg_count = more ? bit_pulses(sh[6]) : acc_cnt;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= M_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            wb        <= 1'b0;
            sh        <= 7'd0;
            bcnt      <= 3'd0;
        end else begin
            unique case (state)
                M_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        wb        <= (cmd_op == OP_WRITE_BYTE);
                        sh        <= cmd_data[6:0];
                        bcnt      <= (cmd_op == OP_WRITE_BYTE) ? 3'd7 : 3'd0;
                        if (acc_cnt == 8'd0) begin
                            state <= M_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    if (more) begin
                        // next bit's train starts straight out of the break
                        sh   <= {sh[5:0], 1'b0};
                        bcnt <= bcnt - 3'd1;
                    end else if (train_done) begin
                        state <= M_DONE;
                        done  <= 1'b1;
                    end
                end
                M_DONE: begin
                    state     <= M_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= M_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    post_pulse_gen #(
        .PWID_CYC  (PWID_CYC),
        .PGAP_CYC  (PGAP_CYC),
        .BREAK_CYC (BREAK_CYC),
        .TMR_W     (TMR_W)
    ) u_pg (
        .clk        (refclk),
        .rst_n      (rst_n),
        .start      (pg_start),
        .count      (pg_count),
        .ack_s      (ack_s),
        .testreq    (testreq),
        .last_ack   (last_ack),
        .train_done (train_done)
    );

endmodule

// File: tb/tb_post_host_master.sv
// Self-checking bench for post_host_master: builds the expected
// testreq waveform per command from pulse groups and compares cycle by cycle.
module tb_post_host_master;

    localparam int PW  = 6;
    localparam int PG  = 6;
    localparam int BRK = 300;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       testreq;
    logic       testack = 1'b0;
    logic       done;
    logic       last_ack;

    int   checks = 0;
    int   errors = 0;
    logic exp_last_ack = 1'b0;
    int   groups[$];

    always #5 refclk = ~refclk;

    post_host_master dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .testreq   (testreq),
        .testack   (testack),
        .done      (done),
        .last_ack  (last_ack)
    );

    // Command -> list of pulse groups, one group per train.
    function automatic void plan(input logic [1:0] op, input logic [7:0] d);
        groups.delete();
        case (op)
            2'd0: if (d != 8'd0) groups.push_back(int'(d));
            2'd1: groups.push_back(4);
            2'd2: groups.push_back(3);
            default: for (int i = 7; i >= 0; i--) groups.push_back(d[i] ? 2 : 1);
        endcase
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d,
                           input string name, input bit hold,
                           input logic [1:0] hop, input int ack_at);
        logic exp_q[$];
        int   len;
        int   bad;
        int   first;
        logic er;
        logic ed;
        plan(op, d);
        foreach (groups[g]) begin
            for (int p = 0; p < groups[g]; p++) begin
                repeat (PW) exp_q.push_back(1'b1);
                repeat (PG) exp_q.push_back(1'b0);
            end
            repeat (BRK) exp_q.push_back(1'b0);
        end
        len = exp_q.size() + 1;
        @(negedge refclk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept actual=%b required=1", name, cmd_ready);
        end
        @(posedge refclk);
        bad   = 0;
        first = 0;
        for (int n = 1; n <= len; n++) begin
            @(negedge refclk);
            if (n == 1) begin
                if (hold) cmd_op = hop;
                else begin
                    cmd_valid = 1'b0;
                    cmd_op    = 2'($urandom);
                end
                cmd_data = 8'($urandom);
            end
            if (n == ack_at) testack = 1'b1;
            er = (n < len) ? exp_q[n-1] : 1'b0;
            ed = (n == len);
            if (testreq !== er || done !== ed || cmd_ready !== 1'b0) begin
                bad++;
                if (first == 0) first = n;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s waveform actual bad_cycles=%0d first_bad_cycle=%0d required bad_cycles=0 done_cycle=%0d",
                     name, bad, first, len);
        end
        if (groups.size() != 0) exp_last_ack = testack;
        checks++;
        if (last_ack !== exp_last_ack) begin
            errors++;
            $display("FAIL %s last_ack actual=%b required=%b", name, last_ack, exp_last_ack);
        end
        if (!hold) begin
            @(negedge refclk);
            checks++;
            if (cmd_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done actual ready=%b done=%b required ready=1 done=0",
                         name, cmd_ready, done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge refclk);
        checks++;
        if (testreq !== 1'b0 || done !== 1'b0 || last_ack !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset actual req=%b done=%b ack=%b ready=%b required 0 0 0 1",
                     testreq, done, last_ack, cmd_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sync();
        testack = 1'b0;
        run_cmd(2'd1, 8'd0, "sync", 1'b0, 2'd0, 0);
    endtask

    task automatic test_output_ack();
        testack = 1'b0;
        run_cmd(2'd2, 8'd0, "output_ack", 1'b0, 2'd0, 26);
    endtask

    task automatic test_write_byte();
        testack = 1'b0;
        run_cmd(2'd3, 8'hA8, "write_a8", 1'b0, 2'd0, 0);
    endtask

    task automatic test_raw();
        testack = ~exp_last_ack;
        run_cmd(2'd0, 8'd0, "raw0", 1'b0, 2'd0, 0);
        testack = 1'b1;
        run_cmd(2'd0, 8'd14, "raw14", 1'b0, 2'd0, 0);
        testack = 1'b0;
        run_cmd(2'd0, 8'd255, "raw255", 1'b0, 2'd0, 0);
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge refclk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        @(posedge refclk);
        @(negedge refclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge refclk);
        checks++;
        if (testreq !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse actual req=%b required=1", testreq);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (testreq !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset actual req=%b ready=%b done=%b required 0 1 0",
                     testreq, cmd_ready, done);
        end
        bad = 0;
        repeat (4) begin
            @(negedge refclk);
            if (done !== 1'b0 || testreq !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_hold actual bad_cycles=%0d required=0", bad);
        end
        rst_n = 1'b1;
        exp_last_ack = 1'b0;
        checks++;
        if (last_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_last_ack actual=%b required=0", last_ack);
        end
        run_cmd(2'd1, 8'd0, "sync_after_reset", 1'b0, 2'd0, 0);
    endtask

    task automatic test_busy_hold();
        testack = 1'b1;
        run_cmd(2'd1, 8'd0, "busy_sync", 1'b1, 2'd2, 0);
        run_cmd(2'd2, 8'd0, "held_output", 1'b0, 2'd0, 0);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            op      = 2'($urandom_range(0, 3));
            d       = (op == 2'd0) ? 8'($urandom_range(1, 40)) : 8'($urandom);
            testack = 1'($urandom);
            run_cmd(op, d, $sformatf("rand%0d", i), 1'b0, 2'd0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_output_ack();
        test_write_byte();
        test_raw();
        test_reset_mid();
        test_busy_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/post_host_master.md
Name: post_host_master

Overview:
- Host-side initiator for the Acorn POST test-port protocol; the other end of the postbox adapter.
- Generates testreq pulse trains (pulse, gap, break) from byte-level commands and samples the adapter's testack reply.
- Used in FPGA loopback harnesses and as a synthesizable driver for postbox adapters, replacing hand-written bench tasks.

Parameters:
- PWID_CYC, 6, testreq high time per pulse in refclk cycles (500 ns at 12 MHz); must be >=1.
- PGAP_CYC, 6, testreq low time after each pulse in cycles; must be >=3 to cover the synchronizer.
- BREAK_CYC, 300, extra low time ending each pulse train in cycles (25 us); must be >=1.
- TMR_W, 16, timer width; must hold max(PWID_CYC, PGAP_CYC, BREAK_CYC).

Ports:
- refclk  in  1  single clock for the block.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a cycle where cmd_valid & cmd_ready.
- cmd_op  in  2  0=RAW, 1=SYNC, 2=OUTPUT, 3=WRITE_BYTE.
- cmd_data  in  8  RAW: pulse count; WRITE_BYTE: data byte; otherwise ignored.
- testreq  out  1  POST request line to the adapter.
- testack  in  1  POST acknowledge from the adapter; asynchronous input.
- done  out  1  one-cycle strobe when the command completes.
- last_ack  out  1  synchronized testack sampled at the end of the most recent train.

Behaviour:
- Reset: testreq=0, done=0, last_ack=0, cmd_ready=1, state IDLE. Reset asserted mid-train drops testreq asynchronously; no done is issued.
- testack passes through a 2-flop synchronizer (ack_s) before any use.
- Train of N pulses:
  - testreq is high for PWID_CYC cycles, then low for PGAP_CYC cycles; this repeats N times.
  - The final gap is followed by BREAK_CYC further low cycles.
  - last_ack is loaded with ack_s in the last cycle of the final pulse's gap.
- Command to trains:
  - RAW: one train of N=cmd_data pulses. N=0 produces no pulses, done on the next cycle, last_ack unchanged.
  - SYNC: one train of 4 pulses.
  - OUTPUT: one train of 3 pulses.
  - WRITE_BYTE: 8 trains, MSB first; a 0 bit sends 1 pulse, a 1 bit sends 2 pulses. Each bit train ends with its own break. last_ack reflects the final bit's train.
- Timing:
  - Acceptance edge is E0. testreq rises in the first cycle after E0.
  - done is high in the single cycle after the last break cycle: cycle P*(PWID_CYC+PGAP_CYC)+T*BREAK_CYC+1 after E0, where P is total pulses and T is number of trains.
  - cmd_ready is low from E0 through the done cycle and returns high in the cycle after done.
- States:
  - IDLE → HIGH on accept with N>=1; IDLE → DONE for RAW N=0.
  - HIGH → GAP after PWID_CYC cycles.
  - GAP → HIGH while pulses remain; GAP → BREAK after the final pulse.
  - BREAK → HIGH if another WRITE_BYTE bit remains (bit counter decrements, shift register shifts left); BREAK → DONE otherwise.
  - DONE → IDLE unconditionally.
- cmd_valid while busy is ignored. The requester holds it; there is no queueing.
- Counters:
  - Pulse counter is 8-bit down-count and never wraps; 255 is the maximum RAW count.
  - Timer is TMR_W bits, loaded with length-1 and counting to 0.
  - Bit counter is 3-bit.
- cmd_op and cmd_data are captured at E0; later changes have no effect.

Decomposition:
- Shared package post_pkg: op-code constants (OP_RAW, OP_SYNC, OP_OUTPUT, OP_WRITE_BYTE), SYNC_PULSES=4, OUTPUT_PULSES=3, default timing constants for 12 MHz.
- One sub-module, post_pulse_gen:
  - Inputs: start, pulse count.
  - Generates HIGH/GAP/BREAK timing and the last_ack sample, and returns train_done.
  - post_host_master holds command decode, bit sequencing, and the done/ready handshake.

Test Plan:
- SYNC after reset → 4 pulses, each 6 high / 6 low, then 300 low; done at E0+349; cmd_ready low throughout; last_ack=0 with testack tied low.
- OUTPUT with an adapter model raising testack during the third pulse → 3 pulses, done at E0+337, last_ack=1.
- WRITE_BYTE 0xA8 → pulse groups 2,1,2,1,2,1,1,1 (11 pulses, 8 breaks), each group followed by 300 low; done at E0+2533 with a single done strobe.
- RAW 0 → no testreq activity, done at E0+1, last_ack unchanged. RAW 14 (INPUT chaser) → 14 pulses, done at E0+469.
- rst_n pulled low mid-pulse of a SYNC → testreq low within the reset edge, no done, cmd_ready=1. A new SYNC after release runs to completion normally.
- cmd_valid held with a different op while busy → ignored until done. The held command is accepted in the cycle cmd_ready returns, with testreq rising the next cycle.
